// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Streaming RV32I instruction encoder. Packs decoded fields (format, opcode,
//   rd, rs1, rs2, funct3, funct7, full immediate) into a 32-bit instruction
//   word. Each word is tagged with an auto-incrementing word address. This is
//   the inverse of the core's decode path. It feeds the instruction-memory
//   write port through one registered output stage at full throughput.
//
// Parameters
//   ADDR_W     width of the word-address counter and of the word counter
//   BASE_ADDR  word address loaded at reset and on clear
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   clear          sync clear of address counter, word counter and err_sticky
//   in_valid/in_ready  input handshake for the decoded fields
//   in_fmt         0=R 1=I 2=S 3=B 4=U 5=J (6,7 illegal -> NOP + out_err)
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//                  instruction fields; in_imm is the full signed byte value
//                  (for U it is the final upper value)
//   out_valid/out_ready  output handshake
//   out_ir         encoded instruction word
//   out_addr       word address of out_ir
//   out_err        word has a format (or, optionally, range/alignment) error
//   err_sticky     OR of every out_err accepted downstream since reset/clear
//   count          words accepted downstream since reset/clear (wraps)
//
// Configuration
//   ENCODER_RANGE_CHECK_EN  when defined, out_err also flags immediates that
//                           do not fit their format. The word is still
//                           encoded, with the immediate truncated.
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int                ADDR_W    = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ir,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  output logic [ADDR_W-1:0] count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP_IR = 32'h0000_0013;  // addi x0,x0,0

  logic              in_hs;
  logic              out_hs;
  logic [31:0]       enc_ir;
  logic              enc_err;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] count_nxt;
  logic              sticky_nxt;

  assign in_ready = !out_valid || out_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

`ifdef ENCODER_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  logic               fits_12;
  logic               fits_b;
  logic               fits_j;

  assign imm_s   = signed'(in_imm);
  assign fits_12 = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
  assign fits_b  = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4094)    && !in_imm[0];
  assign fits_j  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];
`endif

  // Field packing. Fields that a format does not use are ignored.
  always_comb begin
    // NOTE: every always_comb output gets a default first. A path that leaves
    // a signal unassigned would otherwise infer a latch.
    enc_ir  = NOP_IR;
    enc_err = 1'b1;
    case (in_fmt)
      FMT_R: begin
        enc_ir  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err = 1'b0;
      end
      FMT_I: begin
        enc_ir  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
`ifdef ENCODER_RANGE_CHECK_EN
        enc_err = !fits_12;
`else
        enc_err = 1'b0;
`endif
      end
      FMT_S: begin
        enc_ir  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
`ifdef ENCODER_RANGE_CHECK_EN
        enc_err = !fits_12;
`else
        enc_err = 1'b0;
`endif
      end
      FMT_B: begin
        enc_ir  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
`ifdef ENCODER_RANGE_CHECK_EN
        enc_err = !fits_b;
`else
        enc_err = 1'b0;
`endif
      end
      FMT_U: begin
        enc_ir  = {in_imm[31:12], in_rd, in_opcode};
`ifdef ENCODER_RANGE_CHECK_EN
        enc_err = (in_imm[11:0] != 12'd0);
`else
        enc_err = 1'b0;
`endif
      end
      FMT_J: begin
        enc_ir  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
`ifdef ENCODER_RANGE_CHECK_EN
        enc_err = !fits_j;
`else
        enc_err = 1'b0;
`endif
      end
      default: begin
        enc_ir  = NOP_IR;
        enc_err = 1'b1;
      end
    endcase
  end

  // The address counter advances on each downstream acceptance, so a word
  // loaded in the same cycle as a handshake already gets the next address.
  // clear overrides the increment. A pending word keeps the address it
  // latched, because out_addr is only written when a new word is loaded.
  always_comb begin
    addr_nxt   = addr_q;
    count_nxt  = count;
    sticky_nxt = err_sticky;
    if (clear) begin
      addr_nxt   = BASE_ADDR;
      count_nxt  = '0;
      sticky_nxt = 1'b0;
    end else if (out_hs) begin
      addr_nxt   = addr_q + ADDR_W'(1);
      count_nxt  = count + ADDR_W'(1);
      sticky_nxt = err_sticky | out_err;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order the statements are in.
    if (reset) begin
      out_valid  <= 1'b0;
      out_ir     <= '0;
      out_err    <= 1'b0;
      out_addr   <= BASE_ADDR;
      addr_q     <= BASE_ADDR;
      count      <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (in_hs) begin
        out_valid <= 1'b1;
        out_ir    <= enc_ir;
        out_err   <= enc_err;
        out_addr  <= addr_nxt;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
      addr_q     <= addr_nxt;
      count      <= count_nxt;
      err_sticky <= sticky_nxt;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Directed bench for instr_encoder with ADDR_W=2 (so address wrap is cheap).
//   The driver pushes each hand-computed expected word into a queue when its
//   input handshake happens. A monitor pops and compares each word as it is
//   accepted downstream. Direct checks cover reset state, counters,
//   stalls, clear and reset.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int ADDR_W = 2;
`ifdef ENCODER_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  typedef struct {
    logic [31:0]       ir;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset, clear, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]        in_fmt, in_funct3;
  logic [6:0]        in_opcode, in_funct7;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [31:0]       in_imm, out_ir;
  logic [ADDR_W-1:0] out_addr, count;
  logic              out_err, err_sticky;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  int   n_sent = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(2'd0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every word accepted downstream against the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_word", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_ir", out_ir, e.ir);
        check("out_addr", 32'(out_addr), 32'(e.addr));
        check("out_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] exp_ir, input logic exp_err);
    exp_t e;
    bit   done = 0;
    in_valid = 1'b1; in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.ir = exp_ir; e.addr = exp_addr; e.err = exp_err;
        sb_q.push_back(e);
        exp_addr = exp_addr + 1'b1;
        n_sent++;
        done = 1;
      end
    end
    if (!done) check("in_ready_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) done = 1;
    end
    if (!done) check("drain_timeout", 32'(sb_q.size()), 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] base;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    step(); step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ir", out_ir, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // addi x1,x0,5, with a one-cycle latency check
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    check("latency_valid", 32'(out_valid), 32'd1);
    drain();

    // Four back-to-back words: one per cycle
    base = ADDR_W'(n_sent);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,   32'h0020_81B3, 1'b0); // add
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,   32'h4020_81B3, 1'b0); // sub
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,    32'h0020_A423, 1'b0); // sw
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0); // lui
    @(negedge clk);
    check("b2b_count3", 32'(count), 32'(ADDR_W'(base + 2'd3)));
    @(negedge clk);
    check("b2b_count4", 32'(count), 32'(ADDR_W'(base + 2'd4)));
    step();
    drain();

    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFFDF_F0EF, 1'b0);     // jal ra,-4
    send(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, -32'sd1, 32'hFFF1_0113, 1'b0);     // addi -1
    drain();

    // Stall: beq x1,x2,-8 held for 3 cycles
    out_ready = 1'b0;
    base = exp_addr;
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8, 32'hFE20_8CE3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ir", out_ir, 32'hFE20_8CE3);
      check("stall_addr", 32'(out_addr), 32'(base));
      step();
    end
    out_ready = 1'b1;
    drain();

    // Misaligned branch: error only with range checking
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h0020_8163, RC);
    drain();
    check("sticky_b_misalign", 32'(err_sticky), 32'(RC));
    check("count_after_b", 32'(count), 32'(ADDR_W'(n_sent)));

    // Illegal format: NOP and error in both configurations
    send(3'd7, 7'h33, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1);
    drain();
    check("sticky_fmt7", 32'(err_sticky), 32'd1);

    // Immediate boundaries
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h8000_0093, RC);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, -32'sd2048,   32'h8020_A023, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094,     32'h7E20_8FE3, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096,     32'h8020_8063, RC);
    send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 32'h0000_10B7, RC);
    send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,        32'h0000_006F, RC);
    send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h8000_006F, RC);
    send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000F_FFFE, 32'h7FFF_F06F, 1'b0);
    drain();

    // clear coincident with the handshake of a pending errored word
    out_ready = 1'b0;
    send(3'd6, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
    clear = 1'b1;
    out_ready = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    check("clear_count", 32'(count), 32'd0);
    check("clear_sticky", 32'(err_sticky), 32'd0);
    check("clear_word_taken", 32'(out_valid), 32'd0);
    check("clear_sb_empty", 32'(sb_q.size()), 32'd0);
    step();
    exp_addr = '0;
    n_sent = 0;

    // Five words after clear: addresses 0,1,2,3,0
    for (int i = 0; i < 5; i++)
      send(3'd0, 7'h33, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h33 | (32'(i) << 7), 1'b0);
    drain();
    check("wrap_count", 32'(count), 32'd1);

    // reset mid-stream discards the pending word
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_addr", 32'(out_addr), 32'd0);
    step();
    out_ready = 1'b1;
    exp_addr = '0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
